// File: rtl/bus_pkg.sv
// Shared bus definitions for the serial transmitter/receiver pair: field widths,
// CRC-4 polynomial, broadcast mode and the receiver state encoding.
package bus_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned MOD_W  = 2;
    localparam int unsigned CRC_W  = 4;

    localparam logic [CRC_W-1:0] CRC_POLY  = 4'b0011;
    localparam logic [MOD_W-1:0] MOD_BCAST = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        MODE,
        DATA,
        CRC,
        DONE
    } bus_state_e;

endpackage

// File: rtl/bus_crc4.sv
// Serial CRC-4 (x^4+x+1, init 0), one message bit per enabled clock, MSB first.
module bus_crc4
    import bus_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[CRC_W-1] ^ din;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/bus_rx_deserializer.sv
// Serial bus frame receiver: start bit, addr, mode, data, crc (MSB first).
// Define BUS_RX_CRC_CHECK_EN to enable CRC checking and the crc_err pulse.
module bus_rx_deserializer
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MY_ADDR = 4'd1,
    parameter int unsigned       DATA_W  = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              bus_in,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        addr_out,
    output logic [1:0]        mod_out,
    output logic              valid_out,
    output logic              crc_err,
    output logic              busy
);

    localparam int unsigned FRAME_W = ADDR_W + MOD_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(DATA_W);

    bus_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [MOD_W-1:0]    mod_q, mod_d;
    logic                valid_q, valid_d;
    logic                addressed;
    logic                crc_ok;

    logic [ADDR_W-1:0]   rx_addr;
    logic [MOD_W-1:0]    rx_mod;
    logic [DATA_W-1:0]   rx_data;

    assign rx_addr   = shift_q[FRAME_W-1 -: ADDR_W];
    assign rx_mod    = shift_q[DATA_W +: MOD_W];
    assign rx_data   = shift_q[DATA_W-1:0];
    assign addressed = (rx_addr == MY_ADDR) || (rx_mod == MOD_BCAST);

`ifdef BUS_RX_CRC_CHECK_EN
    logic [CRC_W-1:0] crc_rx_q, crc_rx_d;
    logic [CRC_W-1:0] crc_calc;
    logic             crc_err_q, crc_err_d;
    logic             crc_en;

    // CRC covers addr, mode and data only; it is cleared while waiting for a start bit.
    assign crc_en = (state_q == ADDR) || (state_q == MODE) || (state_q == DATA);

    bus_crc4 u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (state_q == IDLE),
        .en      (crc_en),
        .din     (bus_in),
        .crc     (crc_calc)
    );

    assign crc_ok  = (crc_calc == crc_rx_q);
    assign crc_err = crc_err_q;
`else
    assign crc_ok  = 1'b1;
    assign crc_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        addr_d  = addr_q;
        mod_d   = mod_q;
        valid_d = 1'b0;
`ifdef BUS_RX_CRC_CHECK_EN
        crc_rx_d  = crc_rx_q;
        crc_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus_in) state_d = ADDR;
            end
            ADDR: begin
                shift_d = {shift_q[FRAME_W-2:0], bus_in};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    cnt_d   = '0;
                    state_d = MODE;
                end
            end
            MODE: begin
                shift_d = {shift_q[FRAME_W-2:0], bus_in};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MOD_W - 1)) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                shift_d = {shift_q[FRAME_W-2:0], bus_in};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = CRC;
                end
            end
            CRC: begin
`ifdef BUS_RX_CRC_CHECK_EN
                crc_rx_d = {crc_rx_q[CRC_W-2:0], bus_in};
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CRC_W - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (addressed && crc_ok) begin
                    data_d  = rx_data;
                    addr_d  = rx_addr;
                    mod_d   = rx_mod;
                    valid_d = 1'b1;
                end
`ifdef BUS_RX_CRC_CHECK_EN
                else if (addressed) begin
                    crc_err_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            mod_q   <= '0;
            valid_q <= 1'b0;
`ifdef BUS_RX_CRC_CHECK_EN
            crc_rx_q  <= '0;
            crc_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            mod_q   <= mod_d;
            valid_q <= valid_d;
`ifdef BUS_RX_CRC_CHECK_EN
            crc_rx_q  <= crc_rx_d;
            crc_err_q <= crc_err_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign addr_out  = addr_q;
    assign mod_out   = mod_q;
    assign valid_out = valid_q;
    assign busy      = (state_q == ADDR) || (state_q == MODE) ||
                       (state_q == DATA) || (state_q == CRC);

endmodule

// File: tb/tb_bus_rx_deserializer.sv
// Self-checking bench for bus_rx_deserializer; honours BUS_RX_CRC_CHECK_EN like the RTL.
module tb_bus_rx_deserializer;

    localparam logic [3:0] TB_ADDR = 4'd1;
`ifdef BUS_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        bus_in = 1'b0;
    logic [63:0] data_out;
    logic [3:0]  addr_out;
    logic [1:0]  mod_out;
    logic        valid_out;
    logic        crc_err;
    logic        busy;

    bus_rx_deserializer #(.MY_ADDR(TB_ADDR), .DATA_W(64)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus_in    (bus_in),
        .data_out  (data_out),
        .addr_out  (addr_out),
        .mod_out   (mod_out),
        .valid_out (valid_out),
        .crc_err   (crc_err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    logic [63:0] exp_data;
    logic [3:0]  exp_addr;
    logic [1:0]  exp_mod;
    bit          exp_acc;
    bit          exp_err;

    // CRC as the remainder of M(x)*x^4 divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [3:0] a, input logic [1:0] m,
                                           input logic [63:0] d);
        logic [73:0] msg;
        msg = {a, m, d, 4'b0000};
        for (int i = 73; i >= 4; i--) begin
            if (msg[i]) msg[i -: 5] = msg[i -: 5] ^ 5'b10011;
        end
        return msg[3:0];
    endfunction

    task automatic model_frame(input logic [3:0] a, input logic [1:0] m,
                               input logic [63:0] d, input logic [3:0] flip);
        bit hit;
        bit ok;
        hit = (a == TB_ADDR) || (m == 2'b11);
        ok  = !CRC_EN || (flip == 4'd0);
        exp_acc = hit && ok;
        exp_err = hit && !ok;
        if (exp_acc) begin
            exp_data = d;
            exp_addr = a;
            exp_mod  = m;
        end
    endtask

    // Drives one frame then two zero cycles; observes pulses and busy at each negedge.
    task automatic run_frame(input logic [3:0] a, input logic [1:0] m, input logic [63:0] d,
                             input logic [3:0] flip, output int v_cnt, output int e_cnt,
                             output int both, output int busy_cnt, output int v_cyc,
                             output int e_cyc, output int t0);
        logic [74:0] fr;
        fr = {1'b1, a, m, d, ref_crc(a, m, d) ^ flip};
        v_cnt = 0; e_cnt = 0; both = 0; busy_cnt = 0; v_cyc = -1; e_cyc = -1; t0 = 0;
        for (int i = 0; i < 77; i++) begin
            @(negedge clock);
            if (i > 0) begin
                if (valid_out === 1'b1) begin
                    if (v_cnt == 0) v_cyc = cyc;
                    v_cnt++;
                end
                if (crc_err === 1'b1) begin
                    if (e_cnt == 0) e_cyc = cyc;
                    e_cnt++;
                end
                if (valid_out === 1'b1 && crc_err === 1'b1) both++;
                if (busy === 1'b1) busy_cnt++;
            end
            if (i == 0) t0 = cyc;
            bus_in = (i < 75) ? fr[74-i] : 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_in  = 1'b0;
        repeat (3) @(negedge clock);
        exp_data = '0; exp_addr = '0; exp_mod = '0;
        n_cmp++; if (data_out !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out); end
        n_cmp++; if (addr_out !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr_out); end
        n_cmp++; if (mod_out !== 2'd0) begin n_fail++; $display("FAIL reset_mod: got %h want 0", mod_out); end
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_cmp++; if (crc_err !== 1'b0) begin n_fail++; $display("FAIL reset_crc_err: got %b want 0", crc_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic();
        int v, e, b, bz, vc, ec, t0;
        model_frame(4'd1, 2'd0, 64'h1, 4'd0);
        run_frame(4'd1, 2'd0, 64'h1, 4'd0, v, e, b, bz, vc, ec, t0);
        n_cmp++; if (v !== 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d want 1", v); end
        n_cmp++; if (vc - t0 !== 76) begin n_fail++; $display("FAIL basic_latency: got %0d want 76", vc - t0); end
        n_cmp++; if (e !== 0) begin n_fail++; $display("FAIL basic_crc_err: got %0d want 0", e); end
        n_cmp++; if (bz !== 74) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 74", bz); end
        n_cmp++; if (data_out !== 64'h1) begin n_fail++; $display("FAIL basic_data: got %h want 1", data_out); end
        n_cmp++; if (addr_out !== 4'd1) begin n_fail++; $display("FAIL basic_addr: got %h want 1", addr_out); end
        n_cmp++; if (mod_out !== 2'd0) begin n_fail++; $display("FAIL basic_mod: got %h want 0", mod_out); end
    endtask

    task automatic test_crc_err();
        int v, e, b, bz, vc, ec, t0;
        logic [63:0] d;
        d = 64'hDEADBEEF_01234567;
        model_frame(4'd1, 2'd0, d, 4'b0001);
        run_frame(4'd1, 2'd0, d, 4'b0001, v, e, b, bz, vc, ec, t0);
        n_cmp++; if (v !== int'(exp_acc)) begin n_fail++; $display("FAIL crc_valid_count: got %0d want %0d", v, exp_acc); end
        n_cmp++; if (e !== int'(exp_err)) begin n_fail++; $display("FAIL crc_err_count: got %0d want %0d", e, exp_err); end
        n_cmp++; if (b !== 0) begin n_fail++; $display("FAIL crc_both_high: got %0d want 0", b); end
        if (exp_err) begin
            n_cmp++; if (ec - t0 !== 76) begin n_fail++; $display("FAIL crc_err_latency: got %0d want 76", ec - t0); end
        end
        n_cmp++; if (data_out !== exp_data) begin n_fail++; $display("FAIL crc_data: got %h want %h", data_out, exp_data); end
        n_cmp++; if (addr_out !== exp_addr) begin n_fail++; $display("FAIL crc_addr: got %h want %h", addr_out, exp_addr); end
    endtask

    task automatic test_addr_filter();
        int v, e, b, bz, vc, ec, t0;
        logic [63:0] d;
        d = {$urandom, $urandom};
        model_frame(4'd5, 2'd0, d, 4'd0);
        run_frame(4'd5, 2'd0, d, 4'd0, v, e, b, bz, vc, ec, t0);
        n_cmp++; if (v + e !== 0) begin n_fail++; $display("FAIL filter_drop_pulses: got %0d want 0", v + e); end
        n_cmp++; if (data_out !== exp_data) begin n_fail++; $display("FAIL filter_drop_data: got %h want %h", data_out, exp_data); end
        n_cmp++; if (addr_out !== exp_addr) begin n_fail++; $display("FAIL filter_drop_addr: got %h want %h", addr_out, exp_addr); end
        model_frame(4'd5, 2'b11, d, 4'd0);
        run_frame(4'd5, 2'b11, d, 4'd0, v, e, b, bz, vc, ec, t0);
        n_cmp++; if (v !== 1) begin n_fail++; $display("FAIL bcast_valid_count: got %0d want 1", v); end
        n_cmp++; if (addr_out !== 4'd5) begin n_fail++; $display("FAIL bcast_addr: got %h want 5", addr_out); end
        n_cmp++; if (mod_out !== 2'b11) begin n_fail++; $display("FAIL bcast_mod: got %h want 3", mod_out); end
        n_cmp++; if (data_out !== d) begin n_fail++; $display("FAIL bcast_data: got %h want %h", data_out, d); end
    endtask

    task automatic test_reset_midframe();
        int v, e, b, bz, vc, ec, t0, pulses;
        logic [74:0] fr;
        logic [63:0] d;
        d  = {$urandom, $urandom};
        fr = {1'b1, TB_ADDR, 2'b00, d, ref_crc(TB_ADDR, 2'b00, d)};
        // Positions 0..39 are start, addr, mode and data[63:31]; data[30] is replaced by reset.
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            bus_in = fr[74-i];
        end
        @(negedge clock);
        bus_in  = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        exp_data = '0; exp_addr = '0; exp_mod = '0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        pulses = 0;
        if (valid_out === 1'b1 || crc_err === 1'b1) pulses++;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (valid_out !== 1'b0 || crc_err !== 1'b0) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL midreset_pulses: got %0d want 0", pulses); end
        n_cmp++; if (data_out !== exp_data) begin n_fail++; $display("FAIL midreset_data: got %h want %h", data_out, exp_data); end
        d = {$urandom, $urandom};
        model_frame(TB_ADDR, 2'd2, d, 4'd0);
        run_frame(TB_ADDR, 2'd2, d, 4'd0, v, e, b, bz, vc, ec, t0);
        n_cmp++; if (v !== 1) begin n_fail++; $display("FAIL midreset_next_valid: got %0d want 1", v); end
        n_cmp++; if (data_out !== exp_data) begin n_fail++; $display("FAIL midreset_next_data: got %h want %h", data_out, exp_data); end
    endtask

    task automatic test_back_to_back();
        int v1, v2, e, b, bz, vc1, vc2, ec, t0;
        logic [63:0] d1, d2;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        model_frame(TB_ADDR, 2'd1, d1, 4'd0);
        run_frame(TB_ADDR, 2'd1, d1, 4'd0, v1, e, b, bz, vc1, ec, t0);
        model_frame(TB_ADDR, 2'd0, d2, 4'd0);
        run_frame(TB_ADDR, 2'd0, d2, 4'd0, v2, e, b, bz, vc2, ec, t0);
        n_cmp++; if (v1 !== 1 || v2 !== 1) begin n_fail++; $display("FAIL b2b_valid_counts: got %0d,%0d want 1,1", v1, v2); end
        n_cmp++; if (vc2 - vc1 !== 77) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 77", vc2 - vc1); end
        n_cmp++; if (data_out !== d2) begin n_fail++; $display("FAIL b2b_data: got %h want %h", data_out, d2); end
    endtask

    task automatic test_random();
        int v, e, b, bz, vc, ec, t0;
        logic [3:0]  a, flip;
        logic [1:0]  m;
        logic [63:0] d;
        for (int n = 0; n < 40; n++) begin
            a    = ($urandom % 2 == 0) ? TB_ADDR : 4'($urandom);
            m    = 2'($urandom);
            d    = {$urandom, $urandom};
            flip = ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            model_frame(a, m, d, flip);
            run_frame(a, m, d, flip, v, e, b, bz, vc, ec, t0);
            n_cmp++; if (v !== int'(exp_acc)) begin n_fail++; $display("FAIL rnd%0d_valid: got %0d want %0d", n, v, exp_acc); end
            n_cmp++; if (e !== int'(exp_err)) begin n_fail++; $display("FAIL rnd%0d_crc_err: got %0d want %0d", n, e, exp_err); end
            n_cmp++; if (b !== 0) begin n_fail++; $display("FAIL rnd%0d_both: got %0d want 0", n, b); end
            if (exp_acc) begin
                n_cmp++; if (vc - t0 !== 76) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want 76", n, vc - t0); end
            end
            n_cmp++; if (data_out !== exp_data) begin n_fail++; $display("FAIL rnd%0d_data: got %h want %h", n, data_out, exp_data); end
            n_cmp++; if (addr_out !== exp_addr) begin n_fail++; $display("FAIL rnd%0d_addr: got %h want %h", n, addr_out, exp_addr); end
            n_cmp++; if (mod_out !== exp_mod) begin n_fail++; $display("FAIL rnd%0d_mod: got %h want %h", n, mod_out, exp_mod); end
            if ($urandom % 4 == 0) repeat ($urandom_range(1, 5)) @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc_err();
        test_addr_filter();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
